// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges stage stall requests, sequences exception/ERET
// flushes around outstanding bus traffic, and keeps stall/watchdog counters.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
  parameter int          TIMEOUT    = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        ibus_busy,
  input  logic        dbus_busy,
  input  logic        exc_valid,
  input  logic        exc_eret,
  input  logic [31:0] exc_epc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic [31:0] stall_cycles,
  output logic        stall_timeout
);

  localparam int            RW    = $clog2(TIMEOUT + 1);
  localparam logic [RW-1:0] T_MAX = RW'(TIMEOUT);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [31:0]   target_q, target_d;
  logic [31:0]   stall_cycles_q, stall_cycles_d;
  logic [RW-1:0] run_q, run_d;
  logic          stall_timeout_q, stall_timeout_d;

  logic          bus_busy;
  logic [31:0]   exc_target;

  assign bus_busy   = ibus_busy | dbus_busy;
  assign exc_target = exc_eret ? exc_epc : EXC_VECTOR;

  // Outputs are forced quiet while rst is high so a reset mid-DRAIN never
  // leaks a flush or stall into the pipeline.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    stall    = 6'b000000;
    flush    = 1'b0;
    new_pc   = 32'h0;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          if (exc_valid) begin
            if (bus_busy) begin
              stall    = 6'b111111;
              target_d = exc_target;
              state_d  = DRAIN;
            end else begin
              flush  = 1'b1;
              new_pc = exc_target;
            end
          end else if (stallreq_mem) begin
            stall = 6'b011111;
          end else if (stallreq_ex) begin
            stall = 6'b001111;
          end else if (stallreq_id || stallreq_if) begin
            stall = 6'b000111;
          end
        end
        DRAIN: begin
          // New exceptions are ignored here: the first one wins.
          if (bus_busy) begin
            stall = 6'b111111;
          end else begin
            flush   = 1'b1;
            new_pc  = target_q;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    stall_cycles_d  = stall_cycles_q + {31'h0, stall[0]};
    run_d           = '0;
    if (stall[0] && !flush) begin
      run_d = (run_q == T_MAX) ? run_q : run_q + RW'(1);
    end
    stall_timeout_d = stall_timeout_q | (run_d == T_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      target_q        <= 32'h0;
      stall_cycles_q  <= 32'h0;
      run_q           <= '0;
      stall_timeout_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      target_q        <= target_d;
      stall_cycles_q  <= stall_cycles_d;
      run_q           <= run_d;
      stall_timeout_q <= stall_timeout_d;
    end
  end

  assign stall_cycles  = stall_cycles_q;
  assign stall_timeout = stall_timeout_q;

endmodule
